multicycle_control_unit: RTL and testbench

Parametrised multi-cycle sequencer that replaces the single-cycle opcode decoder in the 16-bit RISC core. It accepts one opcode per instruction over a valid/ready handshake. It then steps DECODE → EXEC/MEM → WB and drives the register file, ALU and data-memory strobes one phase at a time. Memory accesses wait on a ready handshake, guarded by a timeout.

---
 rtl/multicycle_control_unit_if.sv | 29 ++
 rtl/multicycle_control_unit.sv | 154 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake/strobe bundle between the core front end and the multicycle sequencer.
interface multicycle_control_unit_if #(parameter int OPCODE_W = 4);
  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [OPCODE_W-1:0] alu_op;
  logic                alu_switch;
  logic                reg_read;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                pc_en;
  logic                illegal;
  logic                timeout;
  logic                busy;

  modport master (
    output instr_valid, opcode, mem_ready,
    input  instr_ready, alu_op, alu_switch, reg_read, reg_write,
           mem_read, mem_write, pc_en, illegal, timeout, busy
  );

  modport slave (
    input  instr_valid, opcode, mem_ready,
    output instr_ready, alu_op, alu_switch, reg_read, reg_write,
           mem_read, mem_write, pc_en, illegal, timeout, busy
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle opcode sequencer: IDLE -> DECODE -> EXEC/MEM_LD/MEM_ST -> WB.
// Optional CU_PERF_CNT_EN adds saturating retired/stall counters.
module multicycle_control_unit #(
  parameter int OPCODE_W     = 4,
  parameter int NUM_ALU_OPS  = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_unit_if.slave bus
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0] retired_count,
  output logic [15:0] stall_count
`endif
);

  localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]    WAIT_LIM = CNT_W'(MEM_WAIT_MAX);
  localparam logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(NUM_ALU_OPS);
  localparam logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(NUM_ALU_OPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM_LD, S_MEM_ST, S_WB
  } state_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  logic is_alu, is_ld, is_st, in_mem, at_limit;

  assign is_alu   = (op_q < OP_LD);
  assign is_ld    = (op_q == OP_LD);
  assign is_st    = (op_q == OP_ST);
  assign in_mem   = (state_q == S_MEM_LD) || (state_q == S_MEM_ST);
  assign at_limit = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    bus.instr_ready = 1'b0;
    bus.alu_switch  = 1'b0;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.pc_en       = 1'b0;
    bus.illegal     = 1'b0;
    bus.timeout     = 1'b0;
    bus.busy        = 1'b0;
    bus.alu_op      = '0;
    // All strobes are gated while rst is high, so nothing leaks before the first reset edge.
    if (!rst) begin
      bus.busy = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          bus.instr_ready = 1'b1;
          if (bus.instr_valid) begin
            op_d    = bus.opcode;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu) begin
            state_d = S_EXEC;
          end else if (is_ld) begin
            state_d = S_MEM_LD;
            wait_d  = '0;
          end else if (is_st) begin
            bus.reg_read = 1'b1;
            state_d      = S_MEM_ST;
            wait_d       = '0;
          end else begin
            bus.illegal = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_EXEC: begin
          bus.alu_switch = 1'b1;
          state_d        = S_WB;
        end
        S_MEM_LD, S_MEM_ST: begin
          if (state_q == S_MEM_LD) begin
            bus.mem_read = 1'b1;
          end else begin
            bus.mem_write = 1'b1;
            bus.reg_read  = 1'b1;
          end
          // Completion beats the limit when both land in the same cycle.
          if (bus.mem_ready) begin
            bus.pc_en = (state_q == S_MEM_ST);
            state_d   = (state_q == S_MEM_LD) ? S_WB : S_IDLE;
          end else if (at_limit) begin
            bus.timeout = 1'b1;
            state_d     = S_IDLE;
          end else if (MEM_WAIT_MAX != 0) begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.pc_en      = 1'b1;
          bus.alu_switch = is_alu;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (bus.alu_switch) bus.alu_op = op_q;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (bus.pc_en && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
    if (!rst && in_mem && !bus.mem_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`else
  logic unused_in_mem;
  assign unused_in_mem = in_mem;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit (OPCODE_W=4, NUM_ALU_OPS=4, MEM_WAIT_MAX=15).
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  multicycle_control_unit_if #(.OPCODE_W(4)) bus();

`ifdef CU_PERF_CNT_EN
  logic [15:0] retired_count, stall_count;
`endif

  multicycle_control_unit #(.OPCODE_W(4), .NUM_ALU_OPS(4), .MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CU_PERF_CNT_EN
    ,
    .retired_count (retired_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // {instr_ready, alu_switch, reg_read, reg_write, mem_read, mem_write, pc_en, illegal, timeout, busy}
  function automatic logic [9:0] outs();
    return {bus.instr_ready, bus.alu_switch, bus.reg_read, bus.reg_write, bus.mem_read,
            bus.mem_write, bus.pc_en, bus.illegal, bus.timeout, bus.busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.instr_valid = 1'b1; bus.opcode = 4'h0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      nvec++;
      if (outs() !== 10'b0 || bus.alu_op !== 4'h0) begin
        $display("FAIL reset cyc%0d: got %b/%h want %b/%h", i, outs(), bus.alu_op, 10'b0, 4'h0);
        nerr++;
      end
    end
    @(negedge clk);
    rst = 1'b0; bus.instr_valid = 1'b0;
    #1;
    nvec++;
    if (outs() !== 10'b1000000000) begin
      $display("FAIL reset_release: got %b want %b", outs(), 10'b1000000000);
      nerr++;
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [9:0] e  [5] = '{10'b1000000000, 10'b0000000001, 10'b0100000001, 10'b0101001001, 10'b1000000000};
    logic [3:0] ao [5] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    for (int i = 0; i < 5; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h2; bus.mem_ready = 1'b0;
      #1;
      nvec++;
      if (outs() !== e[i] || bus.alu_op !== ao[i]) begin
        $display("FAIL alu cyc%0d: got %b/%h want %b/%h", i, outs(), bus.alu_op, e[i], ao[i]);
        nerr++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [9:0] e  [8] = '{10'b1000000000, 10'b0000000001, 10'b0000100001, 10'b0000100001,
                           10'b0000100001, 10'b0000100001, 10'b0001001001, 10'b1000000000};
    logic       mr [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h4; bus.mem_ready = mr[i];
      #1;
      nvec++;
      if (outs() !== e[i] || bus.alu_op !== 4'h0) begin
        $display("FAIL load_wait cyc%0d: got %b/%h want %b/%h", i, outs(), bus.alu_op, e[i], 4'h0);
        nerr++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [9:0] e  [4] = '{10'b1000000000, 10'b0010000001, 10'b0010011001, 10'b1000000000};
    logic       mr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h5; bus.mem_ready = mr[i];
      #1;
      nvec++;
      if (outs() !== e[i]) begin
        $display("FAIL store cyc%0d: got %b want %b", i, outs(), e[i]);
        nerr++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] exp_o;
    // Store never acknowledged: 16 MEM cycles, timeout on the last.
    for (int i = 0; i < 19; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h5; bus.mem_ready = 1'b0;
      if (i == 0 || i == 18) exp_o = 10'b1000000000;
      else if (i == 1)       exp_o = 10'b0010000001;
      else if (i == 17)      exp_o = 10'b0010010011;
      else                   exp_o = 10'b0010010001;
      #1;
      nvec++;
      if (outs() !== exp_o) begin
        $display("FAIL st_timeout cyc%0d: got %b want %b", i, outs(), exp_o);
        nerr++;
      end
      @(negedge clk);
    end
    // Load acknowledged exactly at the limit cycle: completes, no timeout.
    for (int i = 0; i < 20; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h4; bus.mem_ready = (i == 17);
      if (i == 0 || i == 19) exp_o = 10'b1000000000;
      else if (i == 1)       exp_o = 10'b0000000001;
      else if (i == 18)      exp_o = 10'b0001001001;
      else                   exp_o = 10'b0000100001;
      #1;
      nvec++;
      if (outs() !== exp_o) begin
        $display("FAIL ld_limit cyc%0d: got %b want %b", i, outs(), exp_o);
        nerr++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3] = '{4'h6, 4'hA, 4'hF};
    logic [9:0] e   [3] = '{10'b1000000000, 10'b0000000101, 10'b1000000000};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        bus.instr_valid = (i == 0); bus.opcode = ops[k]; bus.mem_ready = 1'b1;
        #1;
        nvec++;
        if (outs() !== e[i] || bus.alu_op !== 4'h0) begin
          $display("FAIL illegal op%h cyc%0d: got %b want %b", ops[k], i, outs(), e[i]);
          nerr++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e [3] = '{10'b1000000000, 10'b0000000001, 10'b0000100001};
    for (int i = 0; i < 3; i++) begin
      bus.instr_valid = (i == 0); bus.opcode = 4'h4; bus.mem_ready = 1'b0;
      #1;
      nvec++;
      if (outs() !== e[i]) begin
        $display("FAIL rst_mid cyc%0d: got %b want %b", i, outs(), e[i]);
        nerr++;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (outs() !== 10'b0) begin
      $display("FAIL rst_mid_hold: got %b want %b", outs(), 10'b0);
      nerr++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (outs() !== 10'b1000000000) begin
      $display("FAIL rst_mid_idle: got %b want %b", outs(), 10'b1000000000);
      nerr++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] e  [9] = '{10'b1000000000, 10'b0000000001, 10'b0100000001, 10'b0101001001, 10'b1000000000,
                           10'b0000000001, 10'b0100000001, 10'b0101001001, 10'b1000000000};
    logic [3:0] ao [9] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0};
    for (int i = 0; i < 9; i++) begin
      bus.instr_valid = (i <= 4); bus.opcode = (i == 0) ? 4'h1 : 4'h3; bus.mem_ready = 1'b0;
      #1;
      nvec++;
      if (outs() !== e[i] || bus.alu_op !== ao[i]) begin
        $display("FAIL b2b cyc%0d: got %b/%h want %b/%h", i, outs(), bus.alu_op, e[i], ao[i]);
        nerr++;
      end
      @(negedge clk);
    end
  endtask

`ifdef CU_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; bus.instr_valid = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      bus.instr_valid = (i <= 12); bus.opcode = (i < 12) ? 4'h1 : 4'h4; bus.mem_ready = (i == 16);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    #1;
    nvec++;
    if (retired_count !== 16'd4 || stall_count !== 16'd2) begin
      $display("FAIL perf: got ret=%0d stall=%0d want ret=4 stall=2", retired_count, stall_count);
      nerr++;
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef CU_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
